// File: rtl/kgp_pkg.sv
// Shared definitions for the KGP-RISC execute stage: branch opcodes,
// branch/PC unit states and the sequential PC increment.
package kgp_pkg;

    typedef enum logic [3:0] {
        BR_NONE = 4'd0,
        BR_B    = 4'd1,
        BR_BR   = 4'd2,
        BR_BLTZ = 4'd3,
        BR_BZ   = 4'd4,
        BR_BNZ  = 4'd5,
        BR_BL   = 4'd6,
        BR_BCY  = 4'd7,
        BR_BNCY = 4'd8,
        BR_HALT = 4'd9
    } br_op_e;

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_RUN   = 2'd1,
        ST_HALT  = 2'd2
    } state_e;

    localparam int unsigned PC_INC = 4;

    // Instruction addresses are word aligned: drop the two byte-offset bits.
    function automatic logic [31:0] align4(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/branch_cond.sv
// Branch condition evaluation. Purely combinational; the carry seen here is
// the registered flag, so a flag-writing branch tests the previous carry.
module branch_cond
    import kgp_pkg::*;
(
    input  logic [3:0]  br_op,
    input  logic [31:0] rs_data,
    input  logic        carry_q,
    output logic        take
);

    br_op_e w_op;

    assign w_op = br_op_e'(br_op);

    // Decide whether the opcode redirects the PC; illegal codes never do.
    always_comb begin
        // NOTE: default assignment first so no path leaves take unassigned (no latch).
        take = 1'b0;
        case (w_op)
            BR_B, BR_BR, BR_BL: take = 1'b1;
            BR_BLTZ:            take = rs_data[31];
            BR_BZ:              take = (rs_data == 32'd0);
            BR_BNZ:             take = (rs_data != 32'd0);
            BR_BCY:             take = carry_q;
            BR_BNCY:            take = ~carry_q;
            default:            take = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_pc_unit.sv
// Program counter, registered ALU flags and RESET/RUN/HALT control for the
// KGP-RISC execute stage. Produces the next PC, the bl link write and a
// one-cycle redirect pulse for squashing fetch.
module branch_pc_unit
    import kgp_pkg::*;
#(
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            instr_valid,
    input  logic [3:0]      br_op,
    input  logic            flag_we,
    input  logic            alu_carry,
    input  logic            alu_zero,
    input  logic            alu_sign,
    input  logic [31:0]     rs_data,
    input  logic [25:0]     imm_target,
    output logic [PC_W-1:0] pc,
    output logic            link_we,
    output logic [31:0]     link_data,
    output logic            taken,
    output logic            halted,
    output logic            carry_q,
    output logic            zero_q,
    output logic            sign_q
);

    state_e          r_state;
    logic [PC_W-1:0] r_pc;
    logic            r_taken;
    logic            r_carry;
    logic            r_zero;
    logic            r_sign;

    br_op_e          w_op;
    logic            w_exec;
    logic            w_take;
    logic [31:0]     w_target;
    logic [PC_W-1:0] w_pc_inc;
    logic [PC_W-1:0] w_pc_next;

    assign w_op     = br_op_e'(br_op);
    // Only RUN executes; RESET and HALT ignore every input.
    assign w_exec   = (r_state == ST_RUN) && instr_valid;
    assign w_pc_inc = r_pc + PC_W'(PC_INC);

    // br jumps through the register; every other branch uses the label address.
    assign w_target  = (w_op == BR_BR) ? align4(rs_data) : align4({6'b0, imm_target});
    assign w_pc_next = w_take ? PC_W'(w_target) : w_pc_inc;

    branch_cond u_branch_cond (
        .br_op   (br_op),
        .rs_data (rs_data),
        .carry_q (r_carry),
        .take    (w_take)
    );

    // Control FSM: one RESET cycle, then RUN until a HALT instruction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_RESET;
        end else begin
            // NOTE: non-blocking for all flop state so every register samples pre-edge values.
            case (r_state)
                ST_RESET: r_state <= ST_RUN;
                ST_RUN:   if (w_exec && (w_op == BR_HALT)) r_state <= ST_HALT;
                ST_HALT:  r_state <= ST_HALT;
                default:  r_state <= ST_RESET;
            endcase
        end
    end

    // PC update and redirect pulse; HALT leaves the PC at the HALT address.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc    <= RESET_PC;
            r_taken <= 1'b0;
        end else begin
            r_taken <= 1'b0;
            if (w_exec && (w_op != BR_HALT)) begin
                r_pc    <= w_pc_next;
                r_taken <= w_take;
            end
        end
    end

    // Flag capture from the ALU; the branch above still sees the old carry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_carry <= 1'b0;
            r_zero  <= 1'b0;
            r_sign  <= 1'b0;
        end else if (w_exec && flag_we) begin
            r_carry <= alu_carry;
            r_zero  <= alu_zero;
            r_sign  <= alu_sign;
        end
    end

    assign pc        = r_pc;
    assign taken     = r_taken;
    assign halted    = (r_state == ST_HALT);
    assign carry_q   = r_carry;
    assign zero_q    = r_zero;
    assign sign_q    = r_sign;
    assign link_we   = w_exec && (w_op == BR_BL);
    assign link_data = 32'(w_pc_inc);

endmodule

// File: tb/tb_branch_pc_unit.sv
// Self-checking bench for branch_pc_unit: directed scenarios with literal
// expectations plus randomized traffic compared every cycle to a reference model.
module tb_branch_pc_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic [3:0]  br_op;
    logic        flag_we;
    logic        alu_carry;
    logic        alu_zero;
    logic        alu_sign;
    logic [31:0] rs_data;
    logic [25:0] imm_target;
    logic [31:0] pc;
    logic        link_we;
    logic [31:0] link_data;
    logic        taken;
    logic        halted;
    logic        carry_q;
    logic        zero_q;
    logic        sign_q;

    int n_cmp  = 0;
    int n_fail = 0;

    branch_pc_unit #(.PC_W(32), .RESET_PC(32'h0)) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .br_op       (br_op),
        .flag_we     (flag_we),
        .alu_carry   (alu_carry),
        .alu_zero    (alu_zero),
        .alu_sign    (alu_sign),
        .rs_data     (rs_data),
        .imm_target  (imm_target),
        .pc          (pc),
        .link_we     (link_we),
        .link_data   (link_data),
        .taken       (taken),
        .halted      (halted),
        .carry_q     (carry_q),
        .zero_q      (zero_q),
        .sign_q      (sign_q)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // mode: 0 = reset cycle, 1 = running, 2 = halted
    int          m_mode  = 0;
    logic [31:0] m_pc    = 32'h0;
    logic        m_c     = 1'b0;
    logic        m_z     = 1'b0;
    logic        m_s     = 1'b0;
    logic        m_taken = 1'b0;

    function automatic bit cond_met(input int op, input logic [31:0] rs, input logic c);
        if (op == 1 || op == 2 || op == 6) return 1'b1;
        if (op == 3) return rs >= 32'h8000_0000;
        if (op == 4) return rs == 0;
        if (op == 5) return rs != 0;
        if (op == 7) return c;
        if (op == 8) return !c;
        return 1'b0;
    endfunction

    function automatic logic [31:0] target_of(input int op, input logic [31:0] rs, input logic [25:0] imm);
        logic [31:0] base;
        base = (op == 2) ? rs : 32'(imm);
        return (base / 4) * 4;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_mode  <= 0;
            m_pc    <= 32'h0;
            m_c     <= 1'b0;
            m_z     <= 1'b0;
            m_s     <= 1'b0;
            m_taken <= 1'b0;
        end else begin
            m_taken <= 1'b0;
            if (m_mode == 0) begin
                m_mode <= 1;
            end else if (m_mode == 1 && instr_valid) begin
                if (flag_we) begin
                    m_c <= alu_carry;
                    m_z <= alu_zero;
                    m_s <= alu_sign;
                end
                if (int'(br_op) == 9) begin
                    m_mode <= 2;
                end else if (cond_met(int'(br_op), rs_data, m_c)) begin
                    m_pc    <= target_of(int'(br_op), rs_data, imm_target);
                    m_taken <= 1'b1;
                end else begin
                    m_pc <= m_pc + 32'd4;
                end
            end
        end
    end

    // Every-cycle comparison, sampled mid-cycle away from the active edge.
    always @(negedge clk) begin
        check("pc", pc, m_pc);
        check("taken", 32'(taken), 32'(m_taken));
        check("halted", 32'(halted), 32'(m_mode == 2));
        check("flags", {29'd0, carry_q, zero_q, sign_q}, {29'd0, m_c, m_z, m_s});
        check("link_we", 32'(link_we), 32'(m_mode == 1 && instr_valid && br_op == 4'd6));
        check("link_data", link_data, m_pc + 32'd4);
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic v, input logic [3:0] op, input logic fwe, input logic c,
                         input logic z, input logic s, input logic [31:0] rs, input logic [25:0] imm);
        instr_valid = v;
        br_op       = op;
        flag_we     = fwe;
        alu_carry   = c;
        alu_zero    = z;
        alu_sign    = s;
        rs_data     = rs;
        imm_target  = imm;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rs_tab [3];
        logic [8:0]  exp_tab;
        logic [3:0]  op_tab [3];
        logic [3:0]  r_op;
        logic [31:0] r_rs;
        int          halt_cnt;

        rst = 1'b0;
        drive(1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 26'd0);
        #3;
        check("rst_pc", pc, 32'h0);
        check("rst_taken", 32'(taken), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_link_we", 32'(link_we), 32'd0);
        check("rst_flags", {29'd0, carry_q, zero_q, sign_q}, 32'd0);
        #9 rst = 1'b1;

        // RESET cycle holds pc, then sequential fetch.
        tick(); check("reset_cycle_pc", pc, 32'h0);
        tick(); check("seq_pc4", pc, 32'h4);
        tick(); check("seq_pc8", pc, 32'h8);
        tick(); check("seq_pc12", pc, 32'hC);
        check("seq_taken", 32'(taken), 32'd0);

        // Carry set then BCY: taken to 0x40.
        drive(1'b1, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 26'd0); tick();
        check("add_carry", 32'(carry_q), 32'd1);
        check("add_pc", pc, 32'h10);
        drive(1'b1, 4'd7, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 26'h40); tick();
        check("bcy_pc", pc, 32'h40);
        check("bcy_taken", 32'(taken), 32'd1);
        drive(1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 26'd0); tick();
        check("bcy_pulse_end", 32'(taken), 32'd0);
        check("after_bcy_pc", pc, 32'h44);

        // Carry clear then BCY: falls through.
        drive(1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 26'd0); tick();
        check("add_nocarry", 32'(carry_q), 32'd0);
        drive(1'b1, 4'd7, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 26'h40); tick();
        check("bcy_fall_pc", pc, 32'h4C);
        check("bcy_fall_taken", 32'(taken), 32'd0);

        // BR masks low bits of the register target.
        drive(1'b1, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_1237, 26'd0); tick();
        check("br_pc", pc, 32'h1234);

        // BL at 0x100: link strobe in the same cycle.
        drive(1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 26'h100); tick();
        check("b_pc", pc, 32'h100);
        drive(1'b1, 4'd6, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 26'h200);
        #1;
        check("bl_link_we", 32'(link_we), 32'd1);
        check("bl_link_data", link_data, 32'h104);
        tick();
        check("bl_pc", pc, 32'h200);
        check("bl_taken", 32'(taken), 32'd1);

        // BZ/BNZ/BLTZ against three register values.
        rs_tab[0] = 32'h0; rs_tab[1] = 32'h5; rs_tab[2] = 32'h8000_0000;
        op_tab[0] = 4'd4;  op_tab[1] = 4'd5;  op_tab[2] = 4'd3;
        exp_tab   = 9'b100_010_011;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                drive(1'b1, op_tab[j], 1'b0, 1'b0, 1'b0, 1'b0, rs_tab[i], 26'h300); tick();
                check($sformatf("cond_rs%0d_op%0d", i, j), 32'(taken), 32'(exp_tab[8 - (i * 3 + j)]));
            end
        end

        // PC wrap at the top of the address space.
        drive(1'b1, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFC, 26'd0); tick();
        check("wrap_setup_pc", pc, 32'hFFFF_FFFC);
        drive(1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 26'd0); tick();
        check("wrap_pc", pc, 32'h0);

        // Reset while taken is high clears everything immediately.
        drive(1'b1, 4'd1, 1'b1, 1'b1, 1'b1, 1'b1, 32'd0, 26'h80); tick();
        check("pre_rst_taken", 32'(taken), 32'd1);
        #1 rst = 1'b0;
        #1;
        check("mid_rst_taken", 32'(taken), 32'd0);
        check("mid_rst_pc", pc, 32'h0);
        check("mid_rst_flags", {29'd0, carry_q, zero_q, sign_q}, 32'd0);
        drive(1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 26'd0);
        #2 rst = 1'b1;
        tick(); check("rst2_reset_cycle_pc", pc, 32'h0);
        tick(); check("rst2_pc4", pc, 32'h4);

        // HALT freezes the PC and ignores later branches.
        drive(1'b1, 4'd9, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 26'd0); tick();
        check("halt_pc", pc, 32'h4);
        check("halt_flag", 32'(halted), 32'd1);
        drive(1'b1, 4'd1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 26'h40); tick();
        check("halt_hold_pc", pc, 32'h4);
        check("halt_no_taken", 32'(taken), 32'd0);
        check("halt_no_flags", 32'(carry_q), 32'd0);
        rst = 1'b0;
        #1 check("halt_rst_clear", 32'(halted), 32'd0);
        rst = 1'b1;
        tick();

        // Randomized traffic with occasional resets; checked by the model every cycle.
        halt_cnt = 0;
        for (int k = 0; k < 2000; k++) begin
            r_op = 4'($urandom_range(0, 15));
            if (r_op == 4'd9 && $urandom_range(0, 7) != 0) r_op = 4'd0;
            case ($urandom_range(0, 3))
                0:       r_rs = 32'd0;
                1:       r_rs = 32'($urandom_range(1, 64));
                2:       r_rs = 32'h8000_0000 | $urandom;
                default: r_rs = $urandom;
            endcase
            drive($urandom_range(0, 7) != 0, r_op, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  r_rs, 26'($urandom));
            if (m_mode == 2) halt_cnt++;
            else halt_cnt = 0;
            if (halt_cnt > 3 || $urandom_range(0, 199) == 0) begin
                rst = 1'b0;
                #2 rst = 1'b1;
                halt_cnt = 0;
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
